// File: rtl/usb_phy_filt.sv
// usb_phy_filt: USB FS/LS receive front-end.
// Optional pad synchroniser, per-line run-length glitch filter, J/K/SE0/SE1
// line-state decode, post-transmit RX blanking and SE0 bus-reset detection.
// Every output is driven from a register, so pads never reach an output
// through combinational logic.
module usb_phy_filt #(
    parameter int SAMPLES      = 2,
    parameter int SYNC_STAGES  = 0,
    parameter int FILT_LEN     = 2,
    parameter int TX_BLANK     = 2,
    parameter int RESET_CYCLES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SAMPLES-1:0] pad_dp_s,
    input  logic [SAMPLES-1:0] pad_dn_s,
    input  logic               tx_en,
    input  logic               cfg_ls,
    output logic               rx_dp,
    output logic               rx_dn,
    output logic               rx_chg,
    output logic [1:0]         line_state,
    output logic               se0_reset,
    output logic               se0_long,
    output logic               rx_blank
);

    localparam int         RUN_W  = 4;
    localparam int         SE0_W  = $clog2(RESET_CYCLES + 1);
    localparam int         BLK_W  = 8;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(RESET_CYCLES);

    // A filter shorter than the samples per clock could flip twice in one clock.
    generate
        if ((FILT_LEN < SAMPLES) || (FILT_LEN > 15) || (FILT_LEN < 1) ||
            (RESET_CYCLES < 1) || (TX_BLANK < 0) || (TX_BLANK > 255)) begin : g_bad_param
            $error("usb_phy_filt: illegal parameter combination");
        end
    endgenerate

    // Walk the samples of one clock in arrival order; returns {f, run}.
    function automatic logic [RUN_W:0] filt_step(input logic f_in,
                                                 input logic [RUN_W-1:0] run_in,
                                                 input logic [SAMPLES-1:0] smp);
        logic             f;
        logic [RUN_W-1:0] run;
        f   = f_in;
        run = run_in;
        for (int i = 0; i < SAMPLES; i++) begin
            if (smp[i] == f) begin
                run = {RUN_W{1'b0}};
            end else if (run + 4'd1 == RUN_W'(FILT_LEN)) begin
                f   = ~f;
                run = {RUN_W{1'b0}};
            end else begin
                run = run + 4'd1;
            end
        end
        return {f, run};
    endfunction

    // Map filtered {dp,dn} to line state; low speed swaps the J/K sense.
    function automatic logic [1:0] decode_ls(input logic dp, input logic dn, input logic ls_mode);
        logic [1:0] st;
        case ({dp, dn})
            2'b00:   st = LS_SE0;
            2'b11:   st = LS_SE1;
            2'b10:   st = ls_mode ? LS_K : LS_J;
            2'b01:   st = ls_mode ? LS_J : LS_K;
            default: st = LS_SE0;
        endcase
        return st;
    endfunction

    // ---------------- optional synchroniser ----------------
    logic [SAMPLES-1:0] smp_dp_s;
    logic [SAMPLES-1:0] smp_dn_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign smp_dp_s = pad_dp_s;
            assign smp_dn_s = pad_dn_s;
        end else begin : g_sync
            logic [SAMPLES-1:0] sync_dp_r [SYNC_STAGES];
            logic [SAMPLES-1:0] sync_dn_r [SYNC_STAGES];

            // Shift raw pad samples through the synchroniser chain, one stage per clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_dp_r[i] <= {SAMPLES{1'b0}};
                        sync_dn_r[i] <= {SAMPLES{1'b0}};
                    end
                end else begin
                    sync_dp_r[0] <= pad_dp_s;
                    sync_dn_r[0] <= pad_dn_s;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_dp_r[i] <= sync_dp_r[i-1];
                        sync_dn_r[i] <= sync_dn_r[i-1];
                    end
                end
            end

            assign smp_dp_s = sync_dp_r[SYNC_STAGES-1];
            assign smp_dn_s = sync_dn_r[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------- state ----------------
    logic             f_dp_r, f_dn_r;
    logic [RUN_W-1:0] run_dp_r, run_dn_r;
    logic [BLK_W-1:0] blank_cnt_r;
    logic [SE0_W-1:0] se0_cnt_r;
    logic             rx_chg_r, rx_blank_r, se0_reset_r, se0_long_r;
    logic [1:0]       line_state_r;

    logic             f_dp_nxt_s, f_dn_nxt_s;
    logic [RUN_W-1:0] run_dp_nxt_s, run_dn_nxt_s;
    logic [BLK_W-1:0] blank_nxt_s;
    logic             rx_blank_nxt_s;
    logic [1:0]       ls_nxt_s;
    logic             chg_nxt_s;
    logic [SE0_W-1:0] se0_nxt_s;
    logic             se0_hit_s;

    // Next-state for filters, blanking window, line decode and SE0 run counter.
    always_comb begin
        {f_dp_nxt_s, run_dp_nxt_s} = filt_step(f_dp_r, run_dp_r, smp_dp_s);
        {f_dn_nxt_s, run_dn_nxt_s} = filt_step(f_dn_r, run_dn_r, smp_dn_s);

        // The counter is reloaded while transmitting and then runs down;
        // the blank flag looks at the value before the decrement so the
        // window lasts exactly TX_BLANK clocks after tx_en drops.
        if (tx_en) begin
            blank_nxt_s = BLK_W'(TX_BLANK);
        end else if (blank_cnt_r != {BLK_W{1'b0}}) begin
            blank_nxt_s = blank_cnt_r - 8'd1;
        end else begin
            blank_nxt_s = {BLK_W{1'b0}};
        end
        rx_blank_nxt_s = tx_en | (blank_cnt_r != {BLK_W{1'b0}});

        ls_nxt_s  = decode_ls(f_dp_nxt_s, f_dn_nxt_s, cfg_ls);
        chg_nxt_s = ((f_dp_nxt_s != f_dp_r) | (f_dn_nxt_s != f_dn_r)) & ~rx_blank_nxt_s;

        // SE0 run length is measured on the registered line state.
        if ((line_state_r != LS_SE0) || rx_blank_r) begin
            se0_nxt_s = {SE0_W{1'b0}};
        end else if (se0_cnt_r == SE0_MAX) begin
            se0_nxt_s = se0_cnt_r;
        end else begin
            se0_nxt_s = se0_cnt_r + SE0_W'(1);
        end
        se0_hit_s = (se0_nxt_s == SE0_MAX) && (se0_cnt_r != SE0_MAX);
    end

    // Filter state per line: filtered level plus pending opposite-sample run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_dp_r   <= 1'b0;
            f_dn_r   <= 1'b0;
            run_dp_r <= {RUN_W{1'b0}};
            run_dn_r <= {RUN_W{1'b0}};
        end else begin
            f_dp_r   <= f_dp_nxt_s;
            f_dn_r   <= f_dn_nxt_s;
            run_dp_r <= run_dp_nxt_s;
            run_dn_r <= run_dn_nxt_s;
        end
    end

    // Blanking counter, SE0 counter and the registered event/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_cnt_r  <= {BLK_W{1'b0}};
            rx_blank_r   <= 1'b0;
            se0_cnt_r    <= {SE0_W{1'b0}};
            se0_reset_r  <= 1'b0;
            se0_long_r   <= 1'b0;
            rx_chg_r     <= 1'b0;
            line_state_r <= LS_SE0;
        end else begin
            blank_cnt_r  <= blank_nxt_s;
            rx_blank_r   <= rx_blank_nxt_s;
            se0_cnt_r    <= se0_nxt_s;
            se0_reset_r  <= se0_hit_s;
            se0_long_r   <= (se0_nxt_s == SE0_MAX);
            rx_chg_r     <= chg_nxt_s;
            line_state_r <= ls_nxt_s;
        end
    end

    assign rx_dp      = f_dp_r;
    assign rx_dn      = f_dn_r;
    assign rx_chg     = rx_chg_r;
    assign line_state = line_state_r;
    assign se0_reset  = se0_reset_r;
    assign se0_long   = se0_long_r;
    assign rx_blank   = rx_blank_r;

endmodule

// File: tb/tb_usb_phy_filt.sv
// Bench for usb_phy_filt: a default DDR instance and an SDR instance with a
// 2-stage synchroniser and FILT_LEN=3. Expected rx_chg/se0_reset events go
// into per-instance queues with their expected cycle; a monitor pops them.
module tb_usb_phy_filt;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pad_dp, pad_dn;
    logic       tx_en, cfg_ls;
    logic       rx_dp, rx_dn, rx_chg, se0_reset, se0_long, rx_blank;
    logic [1:0] line_state;

    logic       p5_dp, p5_dn, tx5, cfg5;
    logic       r5_dp, r5_dn, r5_chg, r5_se0r, r5_se0l, r5_blank;
    logic [1:0] r5_ls;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        int         kind;   // 1 = rx_chg, 2 = se0_reset
        logic       dp;
        logic       dn;
        logic [1:0] ls;
    } ev_t;

    ev_t q0[$];
    ev_t q5[$];

    usb_phy_filt dut (
        .clk(clk), .rst(rst), .pad_dp_s(pad_dp), .pad_dn_s(pad_dn),
        .tx_en(tx_en), .cfg_ls(cfg_ls), .rx_dp(rx_dp), .rx_dn(rx_dn),
        .rx_chg(rx_chg), .line_state(line_state), .se0_reset(se0_reset),
        .se0_long(se0_long), .rx_blank(rx_blank)
    );

    usb_phy_filt #(.SAMPLES(1), .SYNC_STAGES(2), .FILT_LEN(3)) dut5 (
        .clk(clk), .rst(rst), .pad_dp_s(p5_dp), .pad_dn_s(p5_dn),
        .tx_en(tx5), .cfg_ls(cfg5), .rx_dp(r5_dp), .rx_dn(r5_dn),
        .rx_chg(r5_chg), .line_state(r5_ls), .se0_reset(r5_se0r),
        .se0_long(r5_se0l), .rx_blank(r5_blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int which, input int c, input int kind,
                           input logic dp, input logic dn, input logic [1:0] ls);
        ev_t e;
        e.cyc = c; e.kind = kind; e.dp = dp; e.dn = dn; e.ls = ls;
        if (which == 0) q0.push_back(e);
        else            q5.push_back(e);
    endtask

    task automatic see_ev(input int which, input int kind,
                          input logic dp, input logic dn, input logic [1:0] ls);
        ev_t e;
        n_cmp++;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q5.size() == 0)) begin
            n_bad++;
            $display("FAIL unexpected_ev dut%0d: kind %0d at cycle %0d dp=%0b dn=%0b ls=%0b, none expected",
                     which, kind, cyc, dp, dn, ls);
        end else begin
            if (which == 0) e = q0.pop_front();
            else            e = q5.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.dp !== dp || e.dn !== dn || e.ls !== ls) begin
                n_bad++;
                $display("FAIL ev_dut%0d: got kind=%0d cyc=%0d dp=%0b dn=%0b ls=%0b, expected kind=%0d cyc=%0d dp=%0b dn=%0b ls=%0b",
                         which, kind, cyc, dp, dn, ls, e.kind, e.cyc, e.dp, e.dn, e.ls);
            end
        end
    endtask

    // Monitor: every strobe the DUTs present is matched against the queues.
    always @(negedge clk) begin
        if (rx_chg === 1'b1)    see_ev(0, 1, rx_dp, rx_dn, line_state);
        if (se0_reset === 1'b1) see_ev(0, 2, rx_dp, rx_dn, line_state);
        if (r5_chg === 1'b1)    see_ev(1, 1, r5_dp, r5_dn, r5_ls);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] dp, input logic [1:0] dn);
        pad_dp = dp;
        pad_dn = dn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1; tx_en = 1'b0; cfg_ls = 1'b0;
        drive(2'b00, 2'b00);
        p5_dp = 1'b0; p5_dn = 1'b0; tx5 = 1'b0; cfg5 = 1'b0;
        step(3);

        // Reset values
        chk("rst_rx_dp", rx_dp, 0);
        chk("rst_rx_dn", rx_dn, 0);
        chk("rst_rx_chg", rx_chg, 0);
        chk("rst_line_state", line_state, 0);
        chk("rst_se0_reset", se0_reset, 0);
        chk("rst_se0_long", se0_long, 0);
        chk("rst_rx_blank", rx_blank, 0);
        chk("rst_dut5_outs", {r5_dp, r5_dn, r5_chg, r5_ls, r5_se0r, r5_se0l, r5_blank}, 0);

        // Release into FS idle J
        rst = 1'b0;
        drive(2'b11, 2'b00);
        push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01);
        step(3);

        // T1: single-sample glitches never flip the filtered line
        drive(2'b10, 2'b00); step(1); drive(2'b11, 2'b00); step(2);
        chk("t1_glitch_s0", rx_dp, 1);
        drive(2'b01, 2'b00); step(1); drive(2'b11, 2'b00); step(2);
        chk("t1_glitch_s1", rx_dp, 1);
        // Run carried across the clock boundary does complete a flip
        drive(2'b01, 2'b00); step(1);
        drive(2'b00, 2'b00); push_ev(0, cyc + 1, 1, 1'b0, 1'b0, 2'b00); step(1);
        drive(2'b11, 2'b00); push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01); step(3);

        // T2: clean J->K in one clock, FS then LS polarity
        drive(2'b00, 2'b11); push_ev(0, cyc + 1, 1, 1'b0, 1'b1, 2'b10); step(3);
        chk("t2_fs_k", line_state, 2'b10);
        cfg_ls = 1'b1; step(1);
        chk("t2_ls_swap", line_state, 2'b01);
        drive(2'b11, 2'b00); push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b10); step(3);
        cfg_ls = 1'b0; step(1);
        chk("t2_fs_j", line_state, 2'b01);

        // T5: SDR, 2 sync stages, FILT_LEN=3
        p5_dp = 1'b1; c = cyc;
        push_ev(1, c + 5, 1, 1'b1, 1'b0, 2'b01);
        step(4);
        chk("t5_before_flip", r5_dp, 0);
        step(1);
        chk("t5_at_flip", r5_dp, 1);
        step(2);
        p5_dp = 1'b0; step(2); p5_dp = 1'b1; step(1);
        p5_dp = 1'b0; step(2); p5_dp = 1'b1; step(6);
        chk("t5_split_glitch", r5_dp, 1);
        p5_dp = 1'b0; push_ev(1, cyc + 5, 1, 1'b0, 1'b0, 2'b00); step(7);

        // T4: transmit with toggling pads, then the TX_BLANK tail
        tx_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(2'b00, 2'b11);
            else            drive(2'b11, 2'b00);
            step(1);
            chk("t4_blank_tx", rx_blank, 1);
            chk("t4_track", rx_dp, (i % 2 == 0) ? 0 : 1);
        end
        tx_en = 1'b0;
        drive(2'b00, 2'b11); step(1);
        chk("t4_tail1", rx_blank, 1);
        chk("t4_tail1_dp", rx_dp, 0);
        drive(2'b11, 2'b00); step(1);
        chk("t4_tail2", rx_blank, 1);
        drive(2'b00, 2'b11); push_ev(0, cyc + 1, 1, 1'b0, 1'b1, 2'b10); step(1);
        chk("t4_tail_end", rx_blank, 0);
        drive(2'b11, 2'b00); push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01); step(2);

        // T3: SE0 held long enough for a bus reset
        drive(2'b00, 2'b00); push_ev(0, cyc + 1, 1, 1'b0, 1'b0, 2'b00);
        c = cyc;
        push_ev(0, c + 121, 2, 1'b0, 1'b0, 2'b00);
        step(119);
        chk("t3_long_early", se0_long, 0);
        step(11);
        chk("t3_long_set", se0_long, 1);
        drive(2'b11, 2'b00); push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01); step(1);
        chk("t3_long_hold", se0_long, 1);
        step(1);
        chk("t3_long_drop", se0_long, 0);
        step(2);

        // T6a: reset in the middle of an SE0 count
        drive(2'b00, 2'b00); push_ev(0, cyc + 1, 1, 1'b0, 1'b0, 2'b00); step(61);
        rst = 1'b1; #1;
        chk("t6a_line_state", line_state, 0);
        chk("t6a_se0_long", se0_long, 0);
        chk("t6a_rx_chg", rx_chg, 0);
        step(2);
        rst = 1'b0; c = cyc;
        push_ev(0, c + 120, 2, 1'b0, 1'b0, 2'b00);
        step(125);
        chk("t6a_long_after", se0_long, 1);
        drive(2'b11, 2'b00); push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01); step(3);

        // T6b: reset inside the post-transmit blank window
        tx_en = 1'b1; step(2); tx_en = 1'b0; step(1);
        chk("t6b_pre_blank", rx_blank, 1);
        chk("t6b_pre_dp", rx_dp, 1);
        rst = 1'b1; #1;
        chk("t6b_blank", rx_blank, 0);
        chk("t6b_dp", rx_dp, 0);
        chk("t6b_line_state", line_state, 0);
        step(2);
        rst = 1'b0; push_ev(0, cyc + 1, 1, 1'b1, 1'b0, 2'b01); step(3);
        chk("t6b_blank_after", rx_blank, 0);

        step(5);
        chk("q0_drained", q0.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
